uart_rx_buffered: RTL

UART receiver for the QLA board debug link: the return direction of the existing transmitter (PC TX → FPGA RxD). It deserialises 8N1 frames at 115200 baud from 16× oversampled samples and rejects glitch starts with a 3-sample majority vote. Received bytes are buffered in a small FIFO and presented on a valid/ready port to the echo/control logic in the same baud-clock domain.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_buffered_if.sv | 38 +++
 rtl/sync_fifo_byte.sv | 60 ++++++
 rtl/uart_rx_buffered.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state type; the transmitter uses the same values.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_LO  = 7;
    localparam int unsigned SAMPLE_HI  = 9;
    localparam int unsigned DATA_BITS  = 8;

    localparam int unsigned TICK_W    = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

    typedef logic [DATA_BITS-1:0] rx_byte_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Majority of three samples taken around the bit centre.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Receive-side byte stream: valid/ready handshake plus status pulses and FIFO fill level.
interface uart_rx_buffered_if
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_byte_t         rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_busy;
    logic             frame_err;
    logic             overrun;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output rx_busy,
        output frame_err,
        output overrun,
        output fifo_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  rx_busy,
        input  frame_err,
        input  overrun,
        input  fifo_count
    );

endinterface

// File: rtl/sync_fifo_byte.sv
// Byte FIFO with occupancy count; push and pop in one cycle are both honoured, even when full.
module sync_fifo_byte
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  rx_byte_t                 data_i,
    input  logic                     pop_i,
    output rx_byte_t                 data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rx_byte_t          mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // A pop frees the slot a same-cycle push needs, so full only blocks an unpaired push.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver at 16x oversampling with majority-vote bit decisions and a byte FIFO.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clkuart,
    input  logic                       reset,
    input  logic                       RxD,
    uart_rx_buffered_if.master         rx_if
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  sync1_q;
    logic                  sync2_q;
    rx_state_e             state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    rx_byte_t              shift_q, shift_d;
    logic [1:0]            samp_q, samp_d;
    logic                  push_q, push_d;
    logic                  ferr_q, ferr_d;

    logic                  line;
    logic                  decide;
    logic                  bit_val;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    rx_byte_t              fifo_data;
    logic [CNT_W-1:0]      fifo_count;

    assign line    = sync2_q;
    assign decide  = (tick_q == TICK_W'(SAMPLE_HI));
    assign bit_val = maj3(samp_q[0], samp_q[1], line);

    // Tick count equals cycles since the start edge was seen, so decisions land at tick SAMPLE_HI.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + TICK_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        push_d    = 1'b0;
        ferr_d    = 1'b0;

        if (tick_q == TICK_W'(SAMPLE_LO)) begin
            samp_d[0] = line;
        end
        if (tick_q == TICK_W'(SAMPLE_LO + 1)) begin
            samp_d[1] = line;
        end

        unique case (state_q)
            RX_IDLE: begin
                tick_d = '0;
                if (!line) begin
                    state_d = RX_START;
                    tick_d  = TICK_W'(1);
                end
            end
            RX_START: begin
                if (decide) begin
                    if (bit_val) begin
                        state_d = RX_IDLE;
                        tick_d  = '0;
                    end else begin
                        state_d   = RX_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            RX_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            RX_STOP: begin
                // Leave at the stop-bit centre so a back-to-back start edge is not missed.
                if (decide) begin
                    if (bit_val) begin
                        push_d  = 1'b1;
                        state_d = RX_IDLE;
                        tick_d  = '0;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                tick_d = '0;
                if (line) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Synchroniser resets high so a line held low through reset is not taken as a start.
    always_ff @(posedge clkuart) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RX_IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= RxD;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
        end
    end

    assign fifo_pop = rx_if.rx_ready && !fifo_empty;

    sync_fifo_byte #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clkuart),
        .rst     (reset),
        .push_i  (push_q),
        .data_i  (shift_q),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Overrun depends on a same-cycle pop, which frees the slot for the incoming byte.
    assign rx_if.overrun    = push_q && fifo_full && !fifo_pop;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.rx_busy    = (state_q != RX_IDLE) || !line;
    assign rx_if.rx_data    = fifo_data;
    assign rx_if.rx_valid   = !fifo_empty;
    assign rx_if.fifo_count = fifo_count;

endmodule
